// File: rtl/par_posl_adder.sv
// W-bit ripple-carry adder built from a chain of one-bit full-adder cells,
// with the sum and carry-out captured in an output register (1-cycle latency).

module par_posl_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module par_posl_adder #(
   parameter int W = 16
) (
   input  logic         CLK_i,
   input  logic         rst_i,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         C_in,
   output logic [W-1:0] S,
   output logic         C_out
);

   logic [W:0]   w_carry;
   logic [W-1:0] w_sum;
   logic [W-1:0] r_sum;
   logic         r_carry;

   assign w_carry[0] = C_in;

   // Explicit cell chain keeps the carry path visible as C_in -> c[W].
   for (genvar i = 0; i < W; i++) begin : g_cell
      par_posl_fa u_fa (
         .i_a (A[i]),
         .i_b (B[i]),
         .i_c (w_carry[i]),
         .o_s (w_sum[i]),
         .o_c (w_carry[i+1])
      );
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge CLK_i) begin
      if (rst_i) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_sum   <= w_sum;
         r_carry <= w_carry[W];
      end
   end

   assign S     = r_sum;
   assign C_out = r_carry;

endmodule

// File: tb/tb_par_posl_adder.sv
// Directed and random checks of par_posl_adder at W = 16, 8 and 1 running in parallel.

module tb_par_posl_adder;

   logic        clk;
   logic        rst;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        cin;

   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [0:0]  a1;
   logic [0:0]  b1;

   logic [15:0] s16;
   logic        co16;
   logic [7:0]  s8;
   logic        co8;
   logic [0:0]  s1;
   logic        co1;

   int checks = 0;
   int errors = 0;

   assign a8 = a16[7:0];
   assign b8 = b16[7:0];
   assign a1 = a16[0:0];
   assign b1 = b16[0:0];

   par_posl_adder #(.W(16)) dut16 (
      .CLK_i (clk), .rst_i (rst), .A (a16), .B (b16), .C_in (cin), .S (s16), .C_out (co16)
   );
   par_posl_adder #(.W(8)) dut8 (
      .CLK_i (clk), .rst_i (rst), .A (a8), .B (b8), .C_in (cin), .S (s8), .C_out (co8)
   );
   par_posl_adder #(.W(1)) dut1 (
      .CLK_i (clk), .rst_i (rst), .A (a1), .B (b1), .C_in (cin), .S (s1), .C_out (co1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply operands just after an edge, then step to 1 time unit past the next edge.
   task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b, input logic c);
      rst = r;
      a16 = a;
      b16 = b;
      cin = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 2; n++) begin
         drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
         checks++;
         if ({co16, s16} !== 17'h0) begin
            errors++;
            $display("FAIL reset16 edge %0d: got %h, required %h", n, {co16, s16}, 17'h0);
         end
         checks++;
         if ({co8, s8, co1, s1} !== 11'h0) begin
            errors++;
            $display("FAIL reset8_1 edge %0d: got %h, required %h", n, {co8, s8, co1, s1}, 11'h0);
         end
      end
   endtask

   task automatic test_basic_add();
      drive(1'b0, 16'h1234, 16'h1111, 1'b0);
      checks++;
      if ({co16, s16} !== {1'b0, 16'h2345}) begin
         errors++;
         $display("FAIL basic_add: got %h, required %h", {co16, s16}, {1'b0, 16'h2345});
      end
   endtask

   task automatic test_full_ripple();
      drive(1'b0, 16'hFFFF, 16'h0000, 1'b1);
      checks++;
      if ({co16, s16} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL full_ripple: got %h, required %h", {co16, s16}, {1'b1, 16'h0000});
      end
   endtask

   task automatic test_max_operands();
      drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      checks++;
      if ({co16, s16} !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL max_cin1: got %h, required %h", {co16, s16}, {1'b1, 16'hFFFF});
      end
      checks++;
      if ({co8, s8, co1, s1} !== {1'b1, 8'hFF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL max_cin1_w8_w1: got %h, required %h", {co8, s8, co1, s1}, {1'b1, 8'hFF, 1'b1, 1'b1});
      end
      drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
      checks++;
      if ({co16, s16} !== {1'b1, 16'hFFFE}) begin
         errors++;
         $display("FAIL max_cin0: got %h, required %h", {co16, s16}, {1'b1, 16'hFFFE});
      end
   endtask

   task automatic test_zero();
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      checks++;
      if ({co16, s16, co8, s8, co1, s1} !== 28'h0) begin
         errors++;
         $display("FAIL zero: got %h, required %h", {co16, s16, co8, s8, co1, s1}, 28'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic        vc [5];
      logic [16:0] vexp [5];
      logic [16:0] prev;
      va = '{16'h8000, 16'h00FF, 16'h7FFF, 16'hAAAA, 16'hAAAA};
      vb = '{16'h8000, 16'h0001, 16'h0001, 16'h5555, 16'h5555};
      vc = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
      vexp = '{17'h10000, 17'h00100, 17'h08000, 17'h10000, 17'h0FFFF};
      prev = {co16, s16};
      for (int i = 0; i < 5; i++) begin
         rst = 1'b0;
         a16 = va[i];
         b16 = vb[i];
         cin = vc[i];
         @(negedge clk);
         checks++;
         if ({co16, s16} !== prev) begin
            errors++;
            $display("FAIL hold %0d: got %h, required %h", i, {co16, s16}, prev);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({co16, s16} !== vexp[i]) begin
            errors++;
            $display("FAIL back_to_back %0d: got %h, required %h", i, {co16, s16}, vexp[i]);
         end
         prev = vexp[i];
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] exp17;
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         drive(1'b0, ra, rb, rc);
         exp17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
         checks++;
         if ({co16, s16} !== exp17) begin
            errors++;
            $display("FAIL pre_reset %0d: got %h, required %h", i, {co16, s16}, exp17);
         end
      end
      drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      checks++;
      if ({co16, s16, co8, s8, co1, s1} !== 28'h0) begin
         errors++;
         $display("FAIL mid_reset: got %h, required %h", {co16, s16, co8, s8, co1, s1}, 28'h0);
      end
      ra = 16'hBEEF;
      rb = 16'h1357;
      rc = 1'b1;
      drive(1'b0, ra, rb, rc);
      checks++;
      if ({co16, s16} !== {1'b0, 16'hD247}) begin
         errors++;
         $display("FAIL post_reset: got %h, required %h", {co16, s16}, {1'b0, 16'hD247});
      end
   endtask

   task automatic test_random_regression(input int n);
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] e16;
      logic [8:0]  e8;
      logic [1:0]  e1;
      for (int i = 0; i < n; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         drive(1'b0, ra, rb, rc);
         e16 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
         e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + 9'(rc);
         e1  = {1'b0, ra[0]} + {1'b0, rb[0]} + 2'(rc);
         checks++;
         if ({co16, s16} !== e16) begin
            errors++;
            $display("FAIL rand16 %0d: got %h, required %h", i, {co16, s16}, e16);
         end
         checks++;
         if ({co8, s8} !== e8) begin
            errors++;
            $display("FAIL rand8 %0d: got %h, required %h", i, {co8, s8}, e8);
         end
         checks++;
         if ({co1, s1} !== e1) begin
            errors++;
            $display("FAIL rand1 %0d: got %h, required %h", i, {co1, s1}, e1);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a16 = '0;
      b16 = '0;
      cin = 1'b0;
      test_reset();
      test_basic_add();
      test_full_ripple();
      test_max_operands();
      test_zero();
      test_back_to_back();
      test_reset_midstream();
      test_random_regression(65537);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
